// File: rtl/fifo_rr_dispatcher.sv
// fifo_rr_dispatcher: round-robin consumer of four input FIFOs that routes each
// popped word to one of four output FIFOs by its destination field word[9:8].
// It also owns the threshold init sequence for all attached FIFOs.
// Optional build macro DISPATCH_STATS_EN adds per-destination push counters
// (stat_count).
module fifo_rr_dispatcher #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned WORD_SIZE = 10,
`ifdef DISPATCH_STATS_EN
    parameter int unsigned PTR_SIZE  = 3,
    parameter int unsigned CNT_SIZE  = 8
`else
    parameter int unsigned PTR_SIZE  = 3
`endif
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init_req,
    input  logic [PTR_SIZE-1:0]            cfg_almost_empty_thr,
    input  logic [PTR_SIZE-1:0]            cfg_almost_full_thr,
    input  logic [NUM_PORTS-1:0]           in_empty,
    input  logic [NUM_PORTS*WORD_SIZE-1:0] in_data,
    input  logic [NUM_PORTS-1:0]           out_almost_full,
    output logic [NUM_PORTS-1:0]           in_rd_en,
    output logic [NUM_PORTS-1:0]           out_wr_en,
    output logic [WORD_SIZE-1:0]           out_data,
    output logic                           fifo_init,
    output logic [PTR_SIZE-1:0]            almost_empty_thr,
    output logic [PTR_SIZE-1:0]            almost_full_thr,
    output logic [1:0]                     state,
    output logic                           idle
`ifdef DISPATCH_STATS_EN
    ,
    output logic [NUM_PORTS*CNT_SIZE-1:0]  stat_count
`endif
);

    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     grant_q;
    logic                 in_flight_q;
    logic [PTR_SIZE-1:0]  ae_thr_q;
    logic [PTR_SIZE-1:0]  af_thr_q;

    logic                 any_req;
    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand;
    logic                 pop_c;
    logic [WORD_SIZE-1:0] flight_word;

    assign any_req          = |(~in_empty);
    assign state            = state_q;
    assign almost_empty_thr = ae_thr_q;
    assign almost_full_thr  = af_thr_q;

    // First non-empty port scanning upward from the round-robin pointer
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = rr_ptr_q + IDX_W'(k);
            if (!grant_vld && !in_empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Word popped last cycle, now presented by the granted input FIFO
    always_comb begin
        flight_word = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == IDX_W'(p)) begin
                flight_word = in_data[p*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = init_req ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (init_req) begin
                    state_d = ST_INIT;
                end else if (any_req) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // a word pushed this cycle has completed, so only new pops keep us busy
                if (init_req) begin
                    state_d = ST_INIT;
                end else if (!any_req) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_RESET;
        endcase
    end

    // FSM outputs: pop strobe, push strobe/data, init strobe, idle
    always_comb begin
        in_rd_en  = '0;
        out_wr_en = '0;
        out_data  = '0;
        pop_c     = 1'b0;
        fifo_init = (state_q == ST_INIT);
        idle      = (state_q == ST_IDLE);
        // destination is unknown before the read, so any almost_full blocks the pop
        if (!reset && !init_req && grant_vld && (out_almost_full == '0) &&
            ((state_q == ST_IDLE) || (state_q == ST_ACTIVE))) begin
            pop_c               = 1'b1;
            in_rd_en[grant_idx] = 1'b1;
        end
        if (in_flight_q && !reset) begin
            out_data = flight_word;
            out_wr_en[flight_word[WORD_SIZE-1 -: IDX_W]] = 1'b1;
        end
    end

    // Datapath registers: thresholds, RR pointer, in-flight tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            ae_thr_q    <= PTR_SIZE'(2);
            af_thr_q    <= PTR_SIZE'(6);
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            in_flight_q <= 1'b0;
        end else begin
            if (state_q == ST_INIT) begin
                ae_thr_q <= cfg_almost_empty_thr;
                af_thr_q <= cfg_almost_full_thr;
            end
            in_flight_q <= pop_c;
            if (pop_c) begin
                grant_q  <= grant_idx;
                rr_ptr_q <= grant_idx + IDX_W'(1);
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [NUM_PORTS*CNT_SIZE-1:0] stat_q;

    assign stat_count = stat_q;

    // Saturating per-destination push counters, cleared on reset and on INIT entry
    always_ff @(posedge clk) begin
        if (reset || ((state_d == ST_INIT) && (state_q != ST_INIT))) begin
            stat_q <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                if (out_wr_en[j] && (stat_q[j*CNT_SIZE +: CNT_SIZE] != {CNT_SIZE{1'b1}})) begin
                    stat_q[j*CNT_SIZE +: CNT_SIZE] <= stat_q[j*CNT_SIZE +: CNT_SIZE] + CNT_SIZE'(1);
                end
            end
        end
    end
`else
    // statistics counters are not built in the default configuration
`endif

endmodule

// File: doc/fifo_rr_dispatcher.md
Name: fifo_rr_dispatcher

Overview:
- Consumer stage directly downstream of the four input FIFOs (10-bit words, depth 8) in the transaction layer.
- Pops words round-robin from the non-empty input FIFOs and pushes each word into one of four output FIFOs, selected by the destination field word[9:8].
- Respects output backpressure via the output FIFOs' almost_full flags.
- Owns the init sequence that loads the almost_empty/almost_full thresholds into all attached FIFOs.

Parameters:
- NUM_PORTS, 4, number of input FIFOs and of output FIFOs (fixed at 4; dest field is 2 bits).
- WORD_SIZE, 10, FIFO word width; dest = word[WORD_SIZE-1:WORD_SIZE-2].
- PTR_SIZE, 3, threshold width (log2 of FIFO depth 8).
- CNT_SIZE, 8, width of each statistics counter (optional feature only).

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- init_req  in  1  request to enter INIT and reload thresholds.
- cfg_almost_empty_thr  in  PTR_SIZE  threshold value sampled in INIT.
- cfg_almost_full_thr  in  PTR_SIZE  threshold value sampled in INIT.
- in_empty  in  NUM_PORTS  empty_flag of each input FIFO.
- in_data  in  NUM_PORTS*WORD_SIZE  data_out of each input FIFO; port i occupies bits [i*WORD_SIZE +: WORD_SIZE].
- out_almost_full  in  NUM_PORTS  almost_full_flag of each output FIFO.
- in_rd_en  out  NUM_PORTS  one-hot pop strobe to the input FIFOs.
- out_wr_en  out  NUM_PORTS  one-hot push strobe to the output FIFOs.
- out_data  out  WORD_SIZE  word shared by all output FIFOs.
- fifo_init  out  1  init strobe to all FIFOs.
- almost_empty_thr  out  PTR_SIZE  registered threshold to all FIFOs.
- almost_full_thr  out  PTR_SIZE  registered threshold to all FIFOs.
- state  out  2  current FSM state.
- idle  out  1  high when nothing is left to move.

Behaviour:
- Reset values: in_rd_en=0, out_wr_en=0, out_data=0, fifo_init=0, almost_empty_thr=2, almost_full_thr=6, state=RESET, idle=0, RR pointer=0, in-flight flag=0.
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- RESET: the first cycle after reset deasserts goes to INIT.
- INIT:
  - fifo_init=1.
  - Thresholds register cfg_* on every INIT cycle.
  - Stays in INIT while init_req=1; otherwise moves to IDLE.
  - No pops or pushes occur in INIT.
- IDLE/ACTIVE:
  - init_req=1 forces INIT at the next edge.
  - A pop already issued still completes its push in the following cycle.
  - ACTIVE moves to IDLE when all in_empty=1 and no word is in flight.
  - IDLE moves to ACTIVE when any in_empty=0.
  - idle=1 only in IDLE state.
- Pop eligibility (cycle t), only in IDLE/ACTIVE with init_req=0:
  - some in_empty[i]=0, and
  - out_almost_full is all zeros (word destination is unknown before the read, so the gate is conservative).
- Arbitration:
  - Pick the first non-empty port scanning from the RR pointer upward, modulo 4.
  - Assert in_rd_en[i] (one-hot) in cycle t.
  - RR pointer becomes i+1 mod 4.
  - When no port is granted, the pointer holds.
- Read latency: the FIFO presents the popped word on in_data one edge after rd_en. The dispatcher captures word i at edge t+1 (in-flight flag plus registered grant index).
- Push, in cycle t+1:
  - out_data = captured word.
  - out_wr_en[dest]=1 for exactly that cycle.
- Throughput: one word per cycle; pops in consecutive cycles are allowed, including from the same port when it is the only non-empty one.
- Backpressure:
  - out_almost_full going high in cycle t blocks the pop in cycle t.
  - The in-flight word from t-1 is still pushed.
  - almost_full_thr must leave at least 1 free slot.
- Simultaneous events: a push (t+1) and a new pop happen in the same cycle.
- Never more than one in_rd_en bit and one out_wr_en bit high.
- Reset mid-operation: an in-flight word is dropped; no push in the cycle after reset.

Optional Feature:
- Macro: DISPATCH_STATS_EN.
- When defined:
  - Adds output stat_count of width NUM_PORTS*CNT_SIZE, one counter per output FIFO.
  - Each counter increments on every out_wr_en[j] and saturates at all-ones.
  - Counters clear on reset and when entering INIT.
- When undefined: the port and the counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then init_req=1 for 2 cycles with cfg 1/5:
  - fifo_init=1 for 2 cycles, then thresholds are 1/5.
  - state goes RESET→INIT→INIT→IDLE.
  - No rd/wr during this sequence.
- Single word 0x2A5 (dest 2) in input 1, others empty:
  - in_rd_en=4'b0010 at t.
  - out_wr_en=4'b0100 with out_data=0x2A5 at t+1.
  - state returns to IDLE at t+2.
- All 4 inputs hold 2 words each:
  - Grant order 0,1,2,3,0,1,2,3 on 8 consecutive cycles.
  - 8 pushes, each routed by its word[9:8].
- out_almost_full[3]=1 raised while pops are streaming:
  - No in_rd_en from the next cycle on.
  - The in-flight word is still pushed.
  - Pops resume the cycle after the flag drops.
- reset pulsed in the cycle after a pop: no out_wr_en afterwards; all outputs return to reset values.
- With DISPATCH_STATS_EN: 3 words to dest 0 and 1 word to dest 3 give counters 3,0,0,1; entering INIT clears them to 0.
